// File: rtl/rcastudioii_mem_arb.sv
// Three-port arbiter (loader > DMA > CPU) in front of a single-port synchronous RAM.
// Optional CPU starvation guard is enabled by defining MEM_ARB_STARVE_GUARD_EN.
module rcastudioii_mem_arb #(
    parameter int          AW           = 12,
    parameter int unsigned ROM_TOP      = 12'h800,
    parameter int          STARVE_LIMIT = 8
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          ld_active,
    input  logic          ld_req,
    input  logic          ld_we,
    input  logic [AW-1:0] ld_addr,
    input  logic [7:0]    ld_wdata,
    output logic          ld_ack,
    input  logic          dma_req,
    input  logic [AW-1:0] dma_addr,
    output logic          dma_ack,
    output logic          dma_rvalid,
    output logic [7:0]    dma_rdata,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [7:0]    cpu_wdata,
    output logic          cpu_ack,
    output logic          cpu_rvalid,
    output logic [7:0]    cpu_rdata,
    output logic          cpu_hold,
    output logic          wp_hit,
    output logic [AW-1:0] ram_addr,
    output logic          ram_we,
    output logic [7:0]    ram_wdata,
    input  logic [7:0]    ram_rdata
);

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACCESS = 1'b1
    } state_t;

    localparam logic [AW-1:0] L_ROM_TOP = AW'(ROM_TOP);

    if (STARVE_LIMIT < 1) begin : g_bad_limit
        $error("STARVE_LIMIT must be at least 1");
    end

    state_t        r_state;
    logic          r_arb_en;
    logic          r_ld_ack;
    logic          r_dma_ack;
    logic          r_cpu_ack;
    logic          r_dma_rvalid;
    logic          r_cpu_rvalid;
    logic          r_acc_we;
    logic [AW-1:0] r_ram_addr;
    logic          r_ram_we;
    logic [7:0]    r_ram_wdata;
    logic          r_wp_hit;
    logic          r_cpu_hold;

    state_t        w_state_next;
    logic          w_ld_ack;
    logic          w_dma_ack;
    logic          w_cpu_ack;
    logic          w_dma_rvalid;
    logic          w_cpu_rvalid;
    logic          w_acc_we;
    logic [AW-1:0] w_ram_addr;
    logic          w_ram_we;
    logic [7:0]    w_ram_wdata;
    logic          w_wp_hit;
    logic          w_cpu_hold;
    logic          w_cpu_grant;
    logic          w_cpu_elig;
    logic          w_cpu_prot;
    logic          w_cpu_first;

    assign w_cpu_elig = cpu_req & ~r_cpu_hold;
    assign w_cpu_prot = (cpu_addr < L_ROM_TOP);

`ifdef MEM_ARB_STARVE_GUARD_EN
    localparam int CW = $clog2(STARVE_LIMIT + 1);
    logic [CW-1:0] r_starve_cnt;

    assign w_cpu_first = (r_starve_cnt >= CW'(STARVE_LIMIT));

    // Saturates at the limit; any gap in cpu_req or a CPU grant restarts the count.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_starve_cnt <= '0;
        end else if (!cpu_req || w_cpu_grant) begin
            r_starve_cnt <= '0;
        end else if (!r_cpu_hold && !w_cpu_first) begin
            r_starve_cnt <= r_starve_cnt + 1'b1;
        end
    end
`else
    assign w_cpu_first = 1'b0;
`endif

    always_comb begin
        w_state_next = r_state;
        w_ld_ack     = 1'b0;
        w_dma_ack    = 1'b0;
        w_cpu_ack    = 1'b0;
        w_dma_rvalid = 1'b0;
        w_cpu_rvalid = 1'b0;
        w_acc_we     = r_acc_we;
        w_ram_addr   = r_ram_addr;
        w_ram_we     = 1'b0;
        w_ram_wdata  = r_ram_wdata;
        w_wp_hit     = 1'b0;
        w_cpu_grant  = 1'b0;
        w_cpu_hold   = ld_active | ld_req | ((r_state == ST_ACCESS) & r_ld_ack);

        case (r_state)
            ST_IDLE: begin
                // r_arb_en keeps the first edge after reset release grant-free
                if (r_arb_en) begin
                    if (ld_req) begin
                        w_state_next = ST_ACCESS;
                        w_ld_ack     = 1'b1;
                        w_acc_we     = ld_we;
                        w_ram_addr   = ld_addr;
                        w_ram_wdata  = ld_wdata;
                        w_ram_we     = ld_we;
                    end else if (w_cpu_elig && (w_cpu_first || !dma_req)) begin
                        w_state_next = ST_ACCESS;
                        w_cpu_ack    = 1'b1;
                        w_cpu_grant  = 1'b1;
                        w_acc_we     = cpu_we;
                        w_ram_addr   = cpu_addr;
                        w_ram_wdata  = cpu_wdata;
                        w_ram_we     = cpu_we & ~w_cpu_prot;
                        w_wp_hit     = cpu_we & w_cpu_prot;
                    end else if (dma_req) begin
                        w_state_next = ST_ACCESS;
                        w_dma_ack    = 1'b1;
                        w_acc_we     = 1'b0;
                        w_ram_addr   = dma_addr;
                    end
                end
            end
            ST_ACCESS: begin
                w_state_next = ST_IDLE;
                w_dma_rvalid = r_dma_ack;
                w_cpu_rvalid = r_cpu_ack & ~r_acc_we;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= ST_IDLE;
            r_arb_en     <= 1'b0;
            r_ld_ack     <= 1'b0;
            r_dma_ack    <= 1'b0;
            r_cpu_ack    <= 1'b0;
            r_dma_rvalid <= 1'b0;
            r_cpu_rvalid <= 1'b0;
            r_acc_we     <= 1'b0;
            r_ram_addr   <= '0;
            r_ram_we     <= 1'b0;
            r_ram_wdata  <= '0;
            r_wp_hit     <= 1'b0;
            r_cpu_hold   <= 1'b0;
        end else begin
            r_state      <= w_state_next;
            r_arb_en     <= 1'b1;
            r_ld_ack     <= w_ld_ack;
            r_dma_ack    <= w_dma_ack;
            r_cpu_ack    <= w_cpu_ack;
            r_dma_rvalid <= w_dma_rvalid;
            r_cpu_rvalid <= w_cpu_rvalid;
            r_acc_we     <= w_acc_we;
            r_ram_addr   <= w_ram_addr;
            r_ram_we     <= w_ram_we;
            r_ram_wdata  <= w_ram_wdata;
            r_wp_hit     <= w_wp_hit;
            r_cpu_hold   <= w_cpu_hold;
        end
    end

    assign ld_ack     = r_ld_ack;
    assign dma_ack    = r_dma_ack;
    assign cpu_ack    = r_cpu_ack;
    assign dma_rvalid = r_dma_rvalid;
    assign cpu_rvalid = r_cpu_rvalid;
    // Read data is gated so every output sits at zero while reset is held.
    assign dma_rdata  = r_dma_rvalid ? ram_rdata : 8'h00;
    assign cpu_rdata  = r_cpu_rvalid ? ram_rdata : 8'h00;
    assign cpu_hold   = r_cpu_hold;
    assign wp_hit     = r_wp_hit;
    assign ram_addr   = r_ram_addr;
    assign ram_we     = r_ram_we;
    assign ram_wdata  = r_ram_wdata;

endmodule

// File: tb/tb_rcastudioii_mem_arb.sv
// Directed bench for rcastudioii_mem_arb with a behavioural 1-cycle-latency RAM.
// Build with MEM_ARB_STARVE_GUARD_EN defined to exercise the starvation guard.
module tb_rcastudioii_mem_arb;

    logic        clk;
    logic        reset_n;
    logic        ld_active;
    logic        ld_req;
    logic        ld_we;
    logic [11:0] ld_addr;
    logic [7:0]  ld_wdata;
    logic        ld_ack;
    logic        dma_req;
    logic [11:0] dma_addr;
    logic        dma_ack;
    logic        dma_rvalid;
    logic [7:0]  dma_rdata;
    logic        cpu_req;
    logic        cpu_we;
    logic [11:0] cpu_addr;
    logic [7:0]  cpu_wdata;
    logic        cpu_ack;
    logic        cpu_rvalid;
    logic [7:0]  cpu_rdata;
    logic        cpu_hold;
    logic        wp_hit;
    logic [11:0] ram_addr;
    logic        ram_we;
    logic [7:0]  ram_wdata;
    logic [7:0]  ram_rdata;

    int n_checks;
    int n_fails;

    logic [7:0] mem [0:4095];

    rcastudioii_mem_arb dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .ld_active  (ld_active),
        .ld_req     (ld_req),
        .ld_we      (ld_we),
        .ld_addr    (ld_addr),
        .ld_wdata   (ld_wdata),
        .ld_ack     (ld_ack),
        .dma_req    (dma_req),
        .dma_addr   (dma_addr),
        .dma_ack    (dma_ack),
        .dma_rvalid (dma_rvalid),
        .dma_rdata  (dma_rdata),
        .cpu_req    (cpu_req),
        .cpu_we     (cpu_we),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_ack    (cpu_ack),
        .cpu_rvalid (cpu_rvalid),
        .cpu_rdata  (cpu_rdata),
        .cpu_hold   (cpu_hold),
        .wp_hit     (wp_hit),
        .ram_addr   (ram_addr),
        .ram_we     (ram_we),
        .ram_wdata  (ram_wdata),
        .ram_rdata  (ram_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (ram_we) mem[ram_addr] <= ram_wdata;
        ram_rdata <= mem[ram_addr];
    end

    task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic ld_write(input logic [11:0] a, input logic [7:0] d, input string tag);
        ld_req = 1'b1; ld_we = 1'b1; ld_addr = a; ld_wdata = d;
        step();
        chk_val({tag, "_ack"}, ld_ack, 1);
        chk_val({tag, "_we"}, ram_we, 1);
        chk_val({tag, "_addr"}, ram_addr, a);
        chk_val({tag, "_wdata"}, ram_wdata, d);
        ld_req = 1'b0;
        step();
        $display("txn ld_write addr=%03h data=%02h", a, d);
    endtask

    task automatic cpu_read(input logic [11:0] a, input logic [7:0] exp, input string tag);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = a;
        step();
        chk_val({tag, "_ack"}, cpu_ack, 1);
        chk_val({tag, "_addr"}, ram_addr, a);
        chk_val({tag, "_we_ack"}, ram_we, 0);
        cpu_req = 1'b0;
        step();
        chk_val({tag, "_rvalid"}, cpu_rvalid, 1);
        chk_val({tag, "_rdata"}, cpu_rdata, exp);
        chk_val({tag, "_we_rd"}, ram_we, 0);
        chk_val({tag, "_ack_low"}, cpu_ack, 0);
        $display("txn cpu_read addr=%03h data=%02h", a, cpu_rdata);
    endtask

    task automatic cpu_write(input logic [11:0] a, input logic [7:0] d, input logic exp_we,
                             input string tag);
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = a; cpu_wdata = d;
        step();
        chk_val({tag, "_ack"}, cpu_ack, 1);
        chk_val({tag, "_we"}, ram_we, exp_we);
        chk_val({tag, "_wp"}, wp_hit, !exp_we);
        if (exp_we) chk_val({tag, "_wdata"}, ram_wdata, d);
        cpu_req = 1'b0; cpu_we = 1'b0;
        step();
        chk_val({tag, "_wp_low"}, wp_hit, 0);
        chk_val({tag, "_no_rvalid"}, cpu_rvalid, 0);
        $display("txn cpu_write addr=%03h data=%02h wp=%0d", a, d, !exp_we);
    endtask

    initial begin
        int n_cpu;
        int n_dma;
        int n_bad;
        n_checks = 0; n_fails = 0;
        reset_n = 1'b0; ld_active = 1'b0;
        ld_req = 1'b0; ld_we = 1'b0; ld_addr = '0; ld_wdata = '0;
        dma_req = 1'b0; dma_addr = '0;
        cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;

        // Reset state
        step(); step();
        chk_val("rst_flags", {ld_ack, dma_ack, cpu_ack, dma_rvalid, cpu_rvalid, ram_we, wp_hit, cpu_hold}, 0);
        chk_val("rst_ram_addr", ram_addr, 0);
        chk_val("rst_ram_wdata", ram_wdata, 0);

        // First grant no earlier than the second edge after release
        reset_n = 1'b1;
        ld_req = 1'b1; ld_we = 1'b1; ld_addr = 12'h900; ld_wdata = 8'h5A;
        step();
        chk_val("first_edge_no_ack", ld_ack, 0);
        step();
        chk_val("second_edge_ack", ld_ack, 1);
        chk_val("second_edge_we", ram_we, 1);
        ld_req = 1'b0;
        step();
        $display("txn ld_write addr=900 data=5a");
        ld_write(12'h100, 8'h11, "ld_rom");
        chk_val("hold_after_ld", cpu_hold, 1);
        step();
        chk_val("hold_clear", cpu_hold, 0);

        // Single CPU read
        cpu_read(12'h900, 8'h5A, "rd900");

        // Write protection
        cpu_write(12'h100, 8'hFF, 1'b0, "wr_prot");
        cpu_write(12'h900, 8'hFF, 1'b1, "wr_ok");
        cpu_read(12'h100, 8'h11, "rd_prot");
        cpu_read(12'h900, 8'hFF, "rd_ok");

        // Simultaneous requests: loader, then DMA, then CPU, two cycles apart
        ld_req = 1'b1; ld_we = 1'b1; ld_addr = 12'h010; ld_wdata = 8'h33;
        dma_req = 1'b1; dma_addr = 12'h900;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 12'h100;
        step();
        chk_val("pri_ld_acks", {ld_ack, dma_ack, cpu_ack}, 3'b100);
        chk_val("pri_ld_we", ram_we, 1);
        ld_req = 1'b0;
        step();
        chk_val("pri_gap1", {ld_ack, dma_ack, cpu_ack}, 3'b000);
        chk_val("pri_gap1_hold", cpu_hold, 1);
        step();
        chk_val("pri_dma_acks", {ld_ack, dma_ack, cpu_ack}, 3'b010);
        chk_val("pri_dma_addr", ram_addr, 12'h900);
        dma_req = 1'b0;
        step();
        chk_val("pri_dma_rvalid", dma_rvalid, 1);
        chk_val("pri_dma_rdata", dma_rdata, 8'hFF);
        chk_val("pri_gap2", {ld_ack, dma_ack, cpu_ack}, 3'b000);
        step();
        chk_val("pri_cpu_acks", {ld_ack, dma_ack, cpu_ack}, 3'b001);
        chk_val("pri_cpu_addr", ram_addr, 12'h100);
        cpu_req = 1'b0;
        step();
        chk_val("pri_cpu_rvalid", cpu_rvalid, 1);
        chk_val("pri_cpu_rdata", cpu_rdata, 8'h11);
        $display("txn priority ld/dma/cpu");

        // Loader active holds the CPU off
        ld_active = 1'b1;
        step();
        chk_val("ldact_hold", cpu_hold, 1);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 12'h900;
        n_cpu = 0; n_bad = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (cpu_ack) n_cpu++;
            if (!cpu_hold) n_bad++;
        end
        chk_val("ldact_no_ack", n_cpu, 0);
        chk_val("ldact_hold_steady", n_bad, 0);
        ld_active = 1'b0;
        step();
        chk_val("ldact_hold_drop", cpu_hold, 0);
        chk_val("ldact_ack_late", cpu_ack, 0);
        step();
        chk_val("ldact_ack", cpu_ack, 1);
        cpu_req = 1'b0;
        step();
        chk_val("ldact_rdata", cpu_rdata, 8'hFF);
        $display("txn cpu_read after ld_active addr=900");

        // DMA vs CPU contention
        dma_req = 1'b1; dma_addr = 12'h010;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 12'h900;
        n_cpu = 0; n_dma = 0; n_bad = 0;
        for (int i = 1; i <= 24; i++) begin
            step();
            if (cpu_ack) begin
                n_cpu++;
                if (n_bad == 0) n_bad = i;
            end
            if (dma_ack) n_dma++;
        end
`ifdef MEM_ARB_STARVE_GUARD_EN
        chk_val("starve_cpu_first", n_bad, 9);
        chk_val("starve_cpu_grants", n_cpu, 2);
        chk_val("starve_dma_grants", n_dma, 10);
`else
        chk_val("strict_cpu_grants", n_cpu, 0);
        chk_val("strict_dma_grants", n_dma, 12);
`endif
        $display("txn contention dma=%0d cpu=%0d", n_dma, n_cpu);
        dma_req = 1'b0; cpu_req = 1'b0;

        // Reset in the middle of a DMA read
        dma_req = 1'b1; dma_addr = 12'h900;
        step();
        chk_val("rstmid_dma_ack", dma_ack, 1);
        reset_n = 1'b0; dma_req = 1'b0;
        #1;
        chk_val("rstmid_flags", {ld_ack, dma_ack, cpu_ack, dma_rvalid, cpu_rvalid, ram_we, wp_hit, cpu_hold}, 0);
        chk_val("rstmid_ram_addr", ram_addr, 0);
        chk_val("rstmid_ram_wdata", ram_wdata, 0);
        chk_val("rstmid_rdata", {dma_rdata, cpu_rdata}, 0);
        n_bad = 0;
        step();
        if (dma_rvalid) n_bad++;
        reset_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            if (dma_rvalid || dma_ack) n_bad++;
        end
        chk_val("rstmid_no_rvalid", n_bad, 0);
        $display("txn dma_read dropped by reset");
        cpu_read(12'h010, 8'h33, "rd_post_rst");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fails);
        $finish;
    end

endmodule
